// File: rtl/store_buffer.sv
// Store buffer between the MEM stage and a 1024-word data memory: stores queue in
// a circular FIFO and drain in order on cycles with no load; loads forward from it.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_write,
  input  logic        cpu_read,
  input  logic [31:0] cpu_write_data,
  output logic [31:0] cpu_read_data,
  output logic        stall,
  output logic        empty,
  output logic [31:0] mem_addr,
  output logic        mem_write_enable,
  output logic        mem_read,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  logic [9:0]       addr_q [DEPTH];
  logic [9:0]       addr_d [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             do_enq;
  logic             do_deq;
  logic             fwd_hit;
  logic [31:0]      fwd_data;
  logic [PTR_W-1:0] fwd_idx;

  assign stall  = cpu_write && (count_q == FULL_COUNT);
  assign empty  = (count_q == '0);
  assign do_enq = cpu_write && !stall;
  assign do_deq = !cpu_read && !empty;

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    fwd_idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_idx = head_q + PTR_W'(i);
      if ((CNT_W'(i) < count_q) && (addr_q[fwd_idx] == cpu_addr[9:0])) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[fwd_idx];
      end
    end
  end

  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (do_enq) begin
      addr_d[tail_q] = cpu_addr[9:0];
      data_d[tail_q] = cpu_write_data;
      tail_d         = tail_q + 1'b1;
    end
    if (do_deq) begin
      head_d = head_q + 1'b1;
    end
    if (do_enq && !do_deq) begin
      count_d = count_q + 1'b1;
    end else if (do_deq && !do_enq) begin
      count_d = count_q - 1'b1;
    end
  end

  // Loads own the memory port; otherwise the head store drains, else idle.
  always_comb begin
    mem_addr         = cpu_addr;
    mem_write_enable = 1'b0;
    mem_read         = 1'b0;
    mem_write_data   = '0;
    cpu_read_data    = mem_read_data;
    if (cpu_read) begin
      mem_read = 1'b1;
      if (fwd_hit) begin
        cpu_read_data = fwd_data;
      end
    end else if (!empty) begin
      mem_addr         = {22'b0, addr_q[head_q]};
      mem_write_data   = data_q[head_q];
      mem_write_enable = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= addr_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic,
// checked against a queue-and-array model of the buffer and the data memory.
module tb_store_buffer;

  localparam int DEPTH = 4;

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr;
  logic        cpu_write;
  logic        cpu_read;
  logic [31:0] cpu_write_data;
  logic [31:0] cpu_read_data;
  logic        stall;
  logic        empty;
  logic [31:0] mem_addr;
  logic        mem_write_enable;
  logic        mem_read;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  logic [31:0] tb_mem [1024];
  logic        mem_clear;
  int          mem_writes = 0;

  logic [31:0] ref_mem [1024];
  entry_t      ref_q [$];

  int checks   = 0;
  int failures = 0;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .cpu_addr         (cpu_addr),
    .cpu_write        (cpu_write),
    .cpu_read         (cpu_read),
    .cpu_write_data   (cpu_write_data),
    .cpu_read_data    (cpu_read_data),
    .stall            (stall),
    .empty            (empty),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_read         (mem_read),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 1004) ? 32'd25 : (32'hC0DE_0000 | 32'(i));
  endfunction

  // Data memory: combinational read, writes commit on the falling edge.
  assign mem_read_data = tb_mem[mem_addr[9:0]];

  always @(negedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) tb_mem[i] <= init_word(i);
    end else if (mem_write_enable) begin
      tb_mem[mem_addr[9:0]] <= mem_write_data;
      mem_writes <= mem_writes + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs just after a rising edge, check combinational
  // outputs before the falling edge, then advance the model past the next edge.
  task automatic step(input logic wr, input logic rd, input logic [31:0] addr,
                      input logic [31:0] wd);
    logic        exp_stall;
    logic        drain;
    logic [31:0] exp_rd;
    entry_t      e;
    cpu_write      = wr;
    cpu_read       = rd;
    cpu_addr       = addr;
    cpu_write_data = wd;
    #2;
    exp_stall = wr && (ref_q.size() == DEPTH);
    drain     = !rd && (ref_q.size() != 0);
    chk("stall", 32'(stall), 32'(exp_stall));
    chk("empty", 32'(empty), 32'(ref_q.size() == 0));
    chk("mem_read", 32'(mem_read), 32'(rd));
    chk("mem_write_enable", 32'(mem_write_enable), 32'(drain));
    if (rd) begin
      exp_rd = ref_mem[addr[9:0]];
      for (int i = ref_q.size() - 1; i >= 0; i--) begin
        if (ref_q[i].addr == addr[9:0]) begin
          exp_rd = ref_q[i].data;
          break;
        end
      end
      chk("load_mem_addr", mem_addr, addr);
      chk("load_data", cpu_read_data, exp_rd);
    end else if (drain) begin
      chk("drain_addr", mem_addr, {22'b0, ref_q[0].addr});
      chk("drain_data", mem_write_data, ref_q[0].data);
    end else begin
      chk("idle_mem_addr", mem_addr, addr);
      chk("idle_wdata", mem_write_data, 32'h0);
      chk("idle_read_data", cpu_read_data, ref_mem[addr[9:0]]);
    end
    @(posedge clk);
    #1;
    if (drain) begin
      e = ref_q.pop_front();
      ref_mem[e.addr] = e.data;
    end
    if (wr && !exp_stall) ref_q.push_back({addr[9:0], wd});
  endtask

  task automatic drain_all();
    int budget = 4 * DEPTH + 4;
    while (ref_q.size() != 0 && budget > 0) begin
      step(1'b0, 1'b0, 32'h0, 32'h0);
      budget--;
    end
    chk("drain_finished", 32'(ref_q.size()), 32'h0);
  endtask

  initial begin
    int base_sel [8] = '{3, 7, 100, 1004, 5, 512, 0, 1023};
    int writes_before;
    int bad_words;
    logic [31:0] a;

    rst = 1'b0;
    cpu_write = 1'b0;
    cpu_read = 1'b0;
    cpu_addr = 32'h0;
    cpu_write_data = 32'h0;
    mem_clear = 1'b1;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    #1;
    chk("reset_empty", 32'(empty), 32'h1);
    chk("reset_stall", 32'(stall), 32'h0);
    chk("reset_we", 32'(mem_write_enable), 32'h0);
    chk("reset_mem_read", 32'(mem_read), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    mem_clear = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] single store then drain to addr 5");
    step(1'b1, 1'b0, 32'd5, 32'hAA);
    step(1'b0, 1'b0, 32'd5, 32'h0);
    step(1'b0, 1'b0, 32'd5, 32'h0);
    chk("mem5_committed", tb_mem[5], 32'hAA);

    $display("[TB] two stores to 7 then forwarded load with read held");
    step(1'b1, 1'b1, 32'd100, 32'h11);
    cpu_addr = 32'd7;
    step(1'b1, 1'b1, 32'd7, 32'h11);
    step(1'b1, 1'b1, 32'd7, 32'h22);
    step(1'b0, 1'b1, 32'd7, 32'h0);
    step(1'b0, 1'b1, 32'd7, 32'h0);
    chk("fwd7_youngest", cpu_read_data, 32'h22);
    drain_all();

    $display("[TB] unbuffered load of 1004");
    step(1'b0, 1'b1, 32'd1004, 32'h0);
    cpu_read = 1'b1;
    cpu_addr = 32'd1004;
    #1;
    chk("load1004", cpu_read_data, 32'd25);

    $display("[TB] fill with read held, stall on fifth store, then release");
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 1'b1, 32'(200 + i), 32'(32'hB000 + i));
    step(1'b1, 1'b0, 32'd204, 32'hB004);
    step(1'b1, 1'b0, 32'd204, 32'hB004);
    drain_all();
    chk("order_last", tb_mem[204], 32'hB004);
    chk("order_first", tb_mem[200], 32'hB000);

    $display("[TB] alias store 1027 forwarded to load of 3");
    step(1'b1, 1'b0, 32'd1027, 32'h3333_0001);
    step(1'b0, 1'b1, 32'd3, 32'h0);
    drain_all();

    $display("[TB] reset during drain with three entries pending");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 32'(300 + i), 32'(32'hD000 + i));
    cpu_write = 1'b0;
    cpu_read  = 1'b0;
    #1;
    chk("pre_reset_we", 32'(mem_write_enable), 32'h1);
    writes_before = mem_writes;
    rst = 1'b0;
    #1;
    chk("rst_we", 32'(mem_write_enable), 32'h0);
    chk("rst_empty", 32'(empty), 32'h1);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_mem_read", 32'(mem_read), 32'h0);
    ref_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b0, 1'b0, 32'd300, 32'h0);
    step(1'b0, 1'b0, 32'd300, 32'h0);
    chk("no_writes_after_reset", 32'(mem_writes), 32'(writes_before));

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      a = 32'($urandom_range(0, 3) << 10) | 32'(base_sel[$urandom_range(0, 7)]);
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 4), a, $urandom);
    end
    drain_all();

    bad_words = 0;
    for (int i = 0; i < 1024; i++) if (tb_mem[i] !== ref_mem[i]) bad_words++;
    chk("final_memory", 32'(bad_words), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the number of buffered stores (power of two, >=2).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port cpu_addr, input, 32 bits: load/store word address from the MEM stage.
REQ-005 The block SHALL have port cpu_write, input, 1 bit: store request.
REQ-006 The block SHALL have port cpu_read, input, 1 bit: load request.
REQ-007 The block SHALL have port cpu_write_data, input, 32 bits: store data.
REQ-008 The block SHALL have port cpu_read_data, output, 32 bits: load result to the MEM stage.
REQ-009 The block SHALL have port stall, output, 1 bit: holds the pipeline while a store cannot be accepted.
REQ-010 The block SHALL have port empty, output, 1 bit: the buffer holds no stores.
REQ-011 The block SHALL have port mem_addr, output, 32 bits: to the data memory.
REQ-012 The block SHALL have port mem_write_enable, output, 1 bit: to the data memory.
REQ-013 The block SHALL have port mem_read, output, 1 bit: to the data memory.
REQ-014 The block SHALL have port mem_write_data, output, 32 bits: to the data memory.
REQ-015 The block SHALL have port mem_read_data, input, 32 bits: combinational read data from the data memory.

Function
REQ-016 The block SHALL hold a circular FIFO of DEPTH {addr[9:0], data[31:0]} entries with head/tail pointers wrapping modulo DEPTH and a count of 0..DEPTH.
REQ-017 The block SHALL compare addresses on addr[9:0] only, matching the 1024-word memory indexing, so aliased addresses are equal.
REQ-018 The block SHALL drive stall combinationally, as cpu_write AND count==DEPTH.
REQ-019 The block SHALL drive empty combinationally, as count==0.
REQ-020 The block SHALL enqueue {cpu_addr[9:0], cpu_write_data} at the tail on a rising edge when cpu_write=1 and stall=0.
REQ-021 In a load cycle (cpu_read=1), the block SHALL drive mem_addr=cpu_addr, mem_read=1 and mem_write_enable=0, and SHALL NOT dequeue; loads have priority over draining.
REQ-022 In a load cycle, the block SHALL drive cpu_read_data combinationally from the data of the youngest valid entry whose address matches, or from mem_read_data if no entry matches.
REQ-023 In a drain cycle (cpu_read=0 and count>0), the block SHALL drive mem_addr={22'b0, head addr}, mem_write_data=head data, mem_write_enable=1 and mem_read=0, and SHALL dequeue the head at the next rising edge (memory commits on the falling edge within that cycle).
REQ-024 In an idle cycle (cpu_read=0 and count==0), the block SHALL drive mem_addr=cpu_addr, mem_write_enable=0, mem_read=0, mem_write_data=0 and cpu_read_data=mem_read_data.
REQ-025 When cpu_read=1 and cpu_write=1 together, forwarding SHALL see only entries present before the edge, and the store SHALL still enqueue if stall=0.
REQ-026 When the buffer is full and cpu_write=1, it SHALL drain if cpu_read=0 with no enqueue (stall=1), and SHALL accept the store in the following cycle (count DEPTH-1 -> DEPTH).
REQ-027 When a drain and an enqueue occur in the same edge, count SHALL be unchanged and both pointers SHALL advance.
REQ-028 Stores SHALL reach memory in program order, with one store per drain cycle.

Reset
REQ-029 When rst=0, the block SHALL immediately clear head, tail, count and all entries to 0, regardless of clk.
REQ-030 While rst=0, outputs SHALL be stall=0, empty=1, mem_write_enable=0 and mem_read=0 (idle-cycle values); stores pending at reset SHALL be discarded.
REQ-031 Operation SHALL resume on the first rising edge after rst returns to 1.

Verification
REQ-032 Reset, then a store to addr 5 with data 0xAA and then idle -> next cycle mem_write_enable=1, mem_addr=5, mem_write_data=0xAA; the cycle after, empty=1 and MEM[5]=0xAA.
REQ-033 Stores 7->0x11 and 7->0x22, then an immediate load of addr 7 with cpu_read held -> cpu_read_data=0x22, mem_write_enable=0 throughout, count stays 2.
REQ-034 A load of addr 1004 with 1004 not buffered and no matching alias -> cpu_read_data=mem_read_data=25.
REQ-035 With cpu_read held, 5 back-to-back stores (DEPTH=4) -> stall=1 on the 5th; releasing cpu_read drains the head, the 5th store enqueues next cycle, and the memory write order equals issue order.
REQ-036 A store to addr 1024+3 then a load of addr 3 -> the load is forwarded from the buffer (alias match).
REQ-037 rst asserted mid-drain with 3 entries pending -> outputs return to idle values asynchronously, empty=1, and no further memory writes occur.
